// File: rtl/reg_dump_reader_pkg.sv
// Shared constants for the register dump frame.
// Used by the dump engine and the host-side frame decoder.
package reg_dump_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_FETCH  = 3'd2,
    ST_SEND   = 3'd3,
    ST_CSUM   = 3'd4,
    ST_FIN    = 3'd5
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

endpackage

// File: rtl/reg_dump_reader.sv
// Register bank dump engine: header, NREGS words, XOR checksum.
// Ports: CLK, RST (async low), START, RD_ADDR/RD_DATA bank
// read, TX_DATA/TX_VALID/TX_READY stream, BUSY, DONE.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int NREGS  = 4,
  parameter int ADDR_W = 2,
  parameter logic [WIDTH-1:0] HEADER = WIDTH'(HEADER_DEFAULT)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              START,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic [WIDTH-1:0]  RD_DATA,
  output logic [WIDTH-1:0]  TX_DATA,
  output logic              TX_VALID,
  input  logic              TX_READY,
  output logic              BUSY,
  output logic              DONE
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);

  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic [WIDTH-1:0]  csum;
  logic              hs;

  assign hs = TX_VALID & TX_READY;

  // TX_DATA doubles as the data latch for the fetched word.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      RD_ADDR  <= '0;
      TX_DATA  <= '0;
      TX_VALID <= 1'b0;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
      idx      <= '0;
      csum     <= '0;
    end else begin
      DONE <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (START) begin
            state    <= ST_HEADER;
            BUSY     <= 1'b1;
            csum     <= '0;
            idx      <= '0;
            RD_ADDR  <= '0;
            TX_VALID <= 1'b1;
            TX_DATA  <= HEADER;
          end
        end
        ST_HEADER: begin
          if (hs) begin
            state    <= ST_FETCH;
            TX_VALID <= 1'b0;
          end
        end
        ST_FETCH: begin
          TX_DATA  <= RD_DATA;
          csum     <= csum ^ RD_DATA;
          TX_VALID <= 1'b1;
          state    <= ST_SEND;
        end
        ST_SEND: begin
          if (hs) begin
            if (idx == LAST) begin
              state   <= ST_CSUM;
              TX_DATA <= csum;
            end else begin
              idx      <= idx + 1'b1;
              RD_ADDR  <= idx + 1'b1;
              TX_VALID <= 1'b0;
              state    <= ST_FETCH;
            end
          end
        end
        ST_CSUM: begin
          if (hs) begin
            state    <= ST_FIN;
            TX_VALID <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b1;
            RD_ADDR  <= '0;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: cycle vectors plus
// hand sequences for reset abort and NREGS=1.
module tb_reg_dump_reader;

  logic       CLK;
  logic       RST;
  logic       start;
  logic       ready;
  logic [1:0] rd_addr;
  logic [7:0] rd_data;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       busy;
  logic       done;

  logic       start1;
  logic [0:0] rd_addr1;
  logic [7:0] rd_data1;
  logic [7:0] tx_data1;
  logic       tx_valid1;
  logic       busy1;
  logic       done1;

  logic [7:0] regs [4];

  int checks;
  int errors;

  assign rd_data  = regs[rd_addr];
  assign rd_data1 = (rd_addr1 == 1'b0) ? 8'hFF : 8'h00;

  reg_dump_reader dut (
    .CLK      (CLK),
    .RST      (RST),
    .START    (start),
    .RD_ADDR  (rd_addr),
    .RD_DATA  (rd_data),
    .TX_DATA  (tx_data),
    .TX_VALID (tx_valid),
    .TX_READY (ready),
    .BUSY     (busy),
    .DONE     (done)
  );

  reg_dump_reader #(
    .WIDTH  (8),
    .NREGS  (1),
    .ADDR_W (1),
    .HEADER (8'hA5)
  ) dut1 (
    .CLK      (CLK),
    .RST      (RST),
    .START    (start1),
    .RD_ADDR  (rd_addr1),
    .RD_DATA  (rd_data1),
    .TX_DATA  (tx_data1),
    .TX_VALID (tx_valid1),
    .TX_READY (1'b1),
    .BUSY     (busy1),
    .DONE     (done1)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic       start;
    logic       ready;
    logic       we;
    logic [1:0] wa;
    logic [7:0] wd;
    logic       valid;
    logic       chk_data;
    logic [7:0] data;
    logic       chk_addr;
    logic [1:0] addr;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm, input int idx,
                     input logic [7:0] got,
                     input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0d: got %h expected %h",
               nm, idx, got, exp);
    end
  endtask

  function automatic vec_t blank();
    vec_t v;
    v.start    = 1'b0;
    v.ready    = 1'b1;
    v.we       = 1'b0;
    v.wa       = 2'd0;
    v.wd       = 8'h00;
    v.valid    = 1'b0;
    v.chk_data = 1'b0;
    v.data     = 8'h00;
    v.chk_addr = 1'b0;
    v.addr     = 2'd0;
    v.busy     = 1'b0;
    v.done     = 1'b0;
    return v;
  endfunction

  // One frame of expected cycles. e0..e3 are the data
  // words the frame must carry; the word with index
  // stall_w (0=header .. 5=checksum) is stalled stall_n
  // cycles; an optional bank write lands in its first
  // stall cycle.
  task automatic gen_frame(
    input logic [7:0] e0, input logic [7:0] e1,
    input logic [7:0] e2, input logic [7:0] e3,
    input int stall_w, input int stall_n,
    input bit spam, input bit hold,
    input bit wr_en, input logic [1:0] wr_a,
    input logic [7:0] wr_d);
    logic [7:0] w [6];
    vec_t v;
    int   n;
    w[0] = 8'hA5;
    w[1] = e0;
    w[2] = e1;
    w[3] = e2;
    w[4] = e3;
    w[5] = e0 ^ e1 ^ e2 ^ e3;
    v = blank();
    v.start    = 1'b1;
    v.chk_addr = 1'b1;
    vq.push_back(v);
    for (int k = 0; k < 6; k++) begin
      if (k >= 1 && k <= 4) begin
        v = blank();
        v.start    = spam;
        v.busy     = 1'b1;
        v.chk_addr = 1'b1;
        v.addr     = 2'(k - 1);
        vq.push_back(v);
      end
      n = (k == stall_w) ? stall_n + 1 : 1;
      for (int j = 0; j < n; j++) begin
        v = blank();
        v.start    = spam;
        v.ready    = (j == n - 1);
        v.valid    = 1'b1;
        v.chk_data = 1'b1;
        v.data     = w[k];
        v.busy     = 1'b1;
        v.chk_addr = (k <= 4);
        v.addr     = (k == 0) ? 2'd0 : 2'(k - 1);
        if (wr_en && k == stall_w && j == 0) begin
          v.we = 1'b1;
          v.wa = wr_a;
          v.wd = wr_d;
        end
        vq.push_back(v);
      end
    end
    v = blank();
    v.start = spam | hold;
    v.done  = 1'b1;
    vq.push_back(v);
    if (!hold) begin
      v = blank();
      v.chk_addr = 1'b1;
      vq.push_back(v);
    end
  endtask

  task automatic run_vecs();
    foreach (vq[i]) begin
      @(negedge CLK);
      chk("valid", i, 8'(tx_valid), 8'(vq[i].valid));
      chk("busy", i, 8'(busy), 8'(vq[i].busy));
      chk("done", i, 8'(done), 8'(vq[i].done));
      if (vq[i].chk_data)
        chk("data", i, tx_data, vq[i].data);
      if (vq[i].chk_addr)
        chk("addr", i, 8'(rd_addr), 8'(vq[i].addr));
      start = vq[i].start;
      ready = vq[i].ready;
      if (vq[i].we)
        regs[vq[i].wa] = vq[i].wd;
    end
    vq.delete();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    RST     = 1'b0;
    start   = 1'b0;
    start1  = 1'b0;
    ready   = 1'b1;
    regs[0] = 8'h11;
    regs[1] = 8'h22;
    regs[2] = 8'h33;
    regs[3] = 8'h44;

    repeat (2) @(negedge CLK);
    chk("rst_valid", 0, 8'(tx_valid), 8'h00);
    chk("rst_data", 0, tx_data, 8'h00);
    chk("rst_addr", 0, 8'(rd_addr), 8'h00);
    chk("rst_busy", 0, 8'(busy), 8'h00);
    chk("rst_done", 0, 8'(done), 8'h00);
    RST = 1'b1;

    // basic frame
    gen_frame(8'h11, 8'h22, 8'h33, 8'h44,
              -1, 0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    run_vecs();

    // backpressure on word 22
    gen_frame(8'h11, 8'h22, 8'h33, 8'h44,
              2, 3, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    run_vecs();

    // START during HEADER/FETCH/SEND/FIN ignored
    gen_frame(8'h11, 8'h22, 8'h33, 8'h44,
              -1, 0, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00);
    run_vecs();

    // START held through FIN: back-to-back frames
    gen_frame(8'h11, 8'h22, 8'h33, 8'h44,
              -1, 0, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00);
    gen_frame(8'h11, 8'h22, 8'h33, 8'h44,
              -1, 0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    run_vecs();

    // reset while word 33 is presented
    @(negedge CLK);
    start = 1'b1;
    ready = 1'b1;
    @(negedge CLK);
    start = 1'b0;
    repeat (6) @(negedge CLK);
    chk("pre_rst_valid", 7, 8'(tx_valid), 8'h01);
    chk("pre_rst_data", 7, tx_data, 8'h33);
    #2 RST = 1'b0;
    #1;
    chk("arst_valid", 0, 8'(tx_valid), 8'h00);
    chk("arst_data", 0, tx_data, 8'h00);
    chk("arst_addr", 0, 8'(rd_addr), 8'h00);
    chk("arst_busy", 0, 8'(busy), 8'h00);
    chk("arst_done", 0, 8'(done), 8'h00);
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK);
      chk("arst_hold_done", c, 8'(done), 8'h00);
      chk("arst_hold_valid", c, 8'(tx_valid), 8'h00);
    end
    RST = 1'b1;
    gen_frame(8'h11, 8'h22, 8'h33, 8'h44,
              -1, 0, 1'b0, 1'b0, 1'b0, 2'd0, 8'h00);
    run_vecs();

    // reg2 rewritten while word 11 is stalled
    gen_frame(8'h11, 8'h22, 8'h00, 8'h44,
              1, 2, 1'b0, 1'b0, 1'b1, 2'd2, 8'h00);
    run_vecs();

    // NREGS=1 instance
    @(negedge CLK);
    start1 = 1'b1;
    @(negedge CLK);
    start1 = 1'b0;
    chk("n1_c1_valid", 1, 8'(tx_valid1), 8'h01);
    chk("n1_c1_data", 1, tx_data1, 8'hA5);
    chk("n1_c1_busy", 1, 8'(busy1), 8'h01);
    @(negedge CLK);
    chk("n1_c2_valid", 2, 8'(tx_valid1), 8'h00);
    @(negedge CLK);
    chk("n1_c3_valid", 3, 8'(tx_valid1), 8'h01);
    chk("n1_c3_data", 3, tx_data1, 8'hFF);
    chk("n1_c3_addr", 3, 8'(rd_addr1), 8'h00);
    @(negedge CLK);
    chk("n1_c4_valid", 4, 8'(tx_valid1), 8'h01);
    chk("n1_c4_data", 4, tx_data1, 8'hFF);
    chk("n1_c4_done", 4, 8'(done1), 8'h00);
    @(negedge CLK);
    chk("n1_c5_done", 5, 8'(done1), 8'h01);
    chk("n1_c5_busy", 5, 8'(busy1), 8'h00);
    chk("n1_c5_valid", 5, 8'(tx_valid1), 8'h00);
    @(negedge CLK);
    chk("n1_c6_done", 6, 8'(done1), 8'h00);
    chk("n1_c6_busy", 6, 8'(busy1), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
